// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU execute unit.
package alu_pkg;

   // Values 0-8 match the older 4-bit ALU control encoding.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_AND  = 4'd7,
      ALU_NDEF = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_MUL  = 4'd11
   } alu_type_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   localparam logic [6:0] F7_ALT = 7'b0100000;
   localparam logic [6:0] F7_MUL = 7'b0000001;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of funct7/funct3/alu_op into an ALU operation.
module alu_seq_decode
   import alu_pkg::*;
#(
   parameter bit MUL_EN = 1'b1
) (
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   input  logic [1:0] alu_op,
   output alu_type_e  alu_type
);

   // Unlisted funct7 on 000/101 falls back to ADD/SRL for compatibility.
   always_comb begin
      alu_type = ALU_NDEF;
      case (alu_op)
         2'b01: alu_type = ALU_ADD;
         2'b10: alu_type = ALU_XOR;
         2'b11: alu_type = ALU_NDEF;
         default: begin
            case (funct3)
               3'b000: begin
                  if (funct7 == F7_ALT)
                     alu_type = ALU_SUB;
                  else if (funct7 == F7_MUL)
                     alu_type = MUL_EN ? ALU_MUL : ALU_NDEF;
                  else
                     alu_type = ALU_ADD;
               end
               3'b001: alu_type = ALU_SLL;
               3'b010: alu_type = ALU_SLT;
               3'b011: alu_type = ALU_SLTU;
               3'b100: alu_type = ALU_XOR;
               3'b101: alu_type = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               3'b110: alu_type = ALU_OR;
               default: alu_type = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute unit: single-cycle ALU plus iterative shift-add multiplier,
// with valid/ready handshakes on input and output.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | ready for a new op (when output slot free or draining)
// ST_MUL  | multiplier iterating, one multiplier bit per cycle
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   input  logic [1:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);

   alu_type_e       alu_type;
   state_e          state;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] mul_step;
   logic [SHW-1:0]  count;
   logic [SHW-1:0]  shamt;
   logic            accept;

   alu_seq_decode #(.MUL_EN(MUL_EN)) u_decode (
      .funct7   (funct7),
      .funct3   (funct3),
      .alu_op   (alu_op),
      .alu_type (alu_type)
   );

   assign shamt    = op_b[SHW-1:0];
   assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign mul_step = acc + (mplier[0] ? mcand : '0);

   // Single-cycle datapath; NDEF (and MUL, handled by the FSM) yield 0.
   always_comb begin
      alu_res = '0;
      case (alu_type)
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_SLL:  alu_res = op_a << shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SRL:  alu_res = op_a >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:   alu_res = op_a | op_b;
         ALU_AND:  alu_res = op_a & op_b;
         default:  alu_res = '0;
      endcase
   end

   // Handshake, output register and multiplier FSM. Bit 0 of the multiplier
   // is folded in at accept so the result appears XLEN cycles after accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         illegal   <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (alu_type == ALU_MUL) begin
                     state     <= ST_MUL;
                     out_valid <= 1'b0;
                     acc       <= op_b[0] ? op_a : '0;
                     mcand     <= op_a << 1;
                     mplier    <= op_b >> 1;
                     count     <= SHW'(1);
                  end else begin
                     out_valid <= 1'b1;
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     illegal   <= (alu_type == ALU_NDEF);
                  end
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               acc    <= mul_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (count == SHW'(XLEN-1)) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b1;
                  result    <= mul_step;
                  zero      <= (mul_step == '0);
                  illegal   <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
